conv_idx_addr: RTL and testbench

- Consumer of the six-deep convolution loop index stream (rr, cc, mm, nn, ii, jj).
- Turns each index tuple into three buffer addresses: input feature map read, weight read, output partial-sum read/write.
- Also tags each tuple with accumulation first/last/end flags.
- Sits between the loop counter and the on-chip buffers/MAC array. Fully pipelined with valid/ready backpressure.

---
 rtl/conv_idx_addr_if.sv | 24 ++
 rtl/conv_idx_addr.sv | 135 +++++++++++++
 tb/tb_conv_idx_addr.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_idx_addr_if.sv
// Handshake bundle for conv_idx_addr: index tuple stream in, address bundle stream out.
// The slave side is the address generator; the master side feeds tuples and drains bundles.
interface conv_idx_addr_if #(
   parameter int LOOP_BIT = 8,
   parameter int ADDR_W   = 20
);
   logic                in_valid;
   logic                in_ready;
   logic [LOOP_BIT-1:0] rr, cc, mm, nn, ii, jj;
   logic                out_valid;
   logic                out_ready;
   logic [ADDR_W-1:0]   in_addr, w_addr, o_addr;
   logic                acc_first, acc_last, layer_end;

   modport slave (
      input  in_valid, rr, cc, mm, nn, ii, jj, out_ready,
      output in_ready, out_valid, in_addr, w_addr, o_addr, acc_first, acc_last, layer_end
   );

   modport master (
      output in_valid, rr, cc, mm, nn, ii, jj, out_ready,
      input  in_ready, out_valid, in_addr, w_addr, o_addr, acc_first, acc_last, layer_end
   );
endinterface

// File: rtl/conv_idx_addr.sv
// Convolution loop-index to buffer-address generator: three-stage pipeline with
// valid/ready backpressure producing input, weight and partial-sum addresses plus accumulation flags.
module conv_idx_addr #(
   parameter int DATA_SIZE = 16,
   parameter int LOOP_BIT  = 8,
   parameter int ADDR_W    = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] R,
   input  logic [DATA_SIZE-1:0] C,
   input  logic [DATA_SIZE-1:0] M,
   input  logic [DATA_SIZE-1:0] N,
   input  logic [DATA_SIZE-1:0] K,
   input  logic [DATA_SIZE-1:0] S,
   input  logic [ADDR_W-1:0]    in_base,
   input  logic [ADDR_W-1:0]    w_base,
   input  logic [ADDR_W-1:0]    o_base,
   conv_idx_addr_if.slave       bus
);
   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [DATA_SIZE-1:0] dim_t;

   // All address arithmetic lives in the ADDR_W ring, so truncation is implicit.
   function automatic addr_t dz(input dim_t v);
      return addr_t'(v);
   endfunction

   function automatic addr_t lz(input logic [LOOP_BIT-1:0] v);
      return addr_t'(v);
   endfunction

   function automatic dim_t ld(input logic [LOOP_BIT-1:0] v);
      return dim_t'(v);
   endfunction

   function automatic addr_t mac(input addr_t a, input addr_t b, input addr_t c);
      return a * b + c;
   endfunction

   logic stall, adv;
   logic first_c, last_c, tail_c;

   assign stall        = bus.out_valid && !bus.out_ready;
   assign adv          = !stall;
   assign bus.in_ready = adv;

   assign first_c = (bus.nn == '0) && (bus.ii == '0) && (bus.jj == '0);
   assign last_c  = (ld(bus.nn) == N - dim_t'(1)) && (ld(bus.ii) == K - dim_t'(1)) &&
                    (ld(bus.jj) == K - dim_t'(1));
   assign tail_c  = (ld(bus.mm) == M - dim_t'(1)) && (ld(bus.cc) == C - dim_t'(1)) &&
                    (ld(bus.rr) == R - dim_t'(1));

   logic  vld_p0, vld_p1, vld_p2;
   logic  first_p0, last_p0, tail_p0;
   logic  first_p1, last_p1, end_p1;
   logic  first_p2, last_p2, end_p2;
   addr_t iw_p0, ih_p0, rsi_p0, csj_p0, kk_p0, ikj_p0, nn_p0, mm_p0, rr_p0, cc_p0;
   addr_t row_p1, iw_p1, csj_p1, mn_p1, kk_p1, ikj_p1, mr_p1, cc_p1;
   addr_t in_addr_p2, w_addr_p2, o_addr_p2;

   // Control and output state: cleared by reset, all stages advance together unless stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0     <= 1'b0;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         first_p0   <= 1'b0;
         last_p0    <= 1'b0;
         tail_p0    <= 1'b0;
         first_p1   <= 1'b0;
         last_p1    <= 1'b0;
         end_p1     <= 1'b0;
         first_p2   <= 1'b0;
         last_p2    <= 1'b0;
         end_p2     <= 1'b0;
         in_addr_p2 <= '0;
         w_addr_p2  <= '0;
         o_addr_p2  <= '0;
      end else if (adv) begin
         // Stage 1: flag compares
         vld_p0     <= bus.in_valid;
         first_p0   <= first_c;
         last_p0    <= last_c;
         tail_p0    <= tail_c;
         // Stage 2: flag combine
         vld_p1     <= vld_p0;
         first_p1   <= first_p0;
         last_p1    <= last_p0;
         end_p1     <= last_p0 && tail_p0;
         // Stage 3: final multiply-add plus base
         vld_p2     <= vld_p1;
         first_p2   <= first_p1;
         last_p2    <= last_p1;
         end_p2     <= end_p1;
         in_addr_p2 <= in_base + mac(row_p1, iw_p1, csj_p1);
         w_addr_p2  <= w_base + mac(mn_p1, kk_p1, ikj_p1);
         o_addr_p2  <= o_base + mac(mr_p1, dz(C), cc_p1);
      end
   end

   // Datapath intermediates carry no reset; their valids gate them.
   always_ff @(posedge clk) begin
      if (adv) begin
         // Stage 1: strided index terms and derived dimensions
         iw_p0  <= mac(dz(C) - addr_t'(1), dz(S), dz(K));
         ih_p0  <= mac(dz(R) - addr_t'(1), dz(S), dz(K));
         rsi_p0 <= mac(lz(bus.rr), dz(S), lz(bus.ii));
         csj_p0 <= mac(lz(bus.cc), dz(S), lz(bus.jj));
         kk_p0  <= mac(dz(K), dz(K), '0);
         ikj_p0 <= mac(lz(bus.ii), dz(K), lz(bus.jj));
         nn_p0  <= lz(bus.nn);
         mm_p0  <= lz(bus.mm);
         rr_p0  <= lz(bus.rr);
         cc_p0  <= lz(bus.cc);
         // Stage 2: row term, map pair index, output row index
         row_p1 <= mac(nn_p0, ih_p0, rsi_p0);
         iw_p1  <= iw_p0;
         csj_p1 <= csj_p0;
         mn_p1  <= mac(mm_p0, dz(N), nn_p0);
         kk_p1  <= kk_p0;
         ikj_p1 <= ikj_p0;
         mr_p1  <= mac(mm_p0, dz(R), rr_p0);
         cc_p1  <= cc_p0;
      end
   end

   assign bus.out_valid = vld_p2;
   assign bus.in_addr   = in_addr_p2;
   assign bus.w_addr    = w_addr_p2;
   assign bus.o_addr    = o_addr_p2;
   assign bus.acc_first = first_p2;
   assign bus.acc_last  = last_p2;
   assign bus.layer_end = end_p2;
endmodule

// File: tb/tb_conv_idx_addr.sv
// Bench for conv_idx_addr: directed and randomized tuples checked against an
// arithmetic reference model and an in-flight queue that tracks expected latency.
module tb_conv_idx_addr;
   localparam int DATA_SIZE = 16;
   localparam int LOOP_BIT  = 8;
   localparam int ADDR_W    = 20;

   typedef struct packed {
      logic [7:0] rr, cc, mm, nn, ii, jj;
   } tuple_t;

   typedef struct packed {
      logic [19:0] in_addr, w_addr, o_addr;
      logic        first, last, lend;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] R, C, M, N, K, S;
   logic [19:0] in_base, w_base, o_base;

   always #5 clk = ~clk;

   conv_idx_addr_if #(.LOOP_BIT(LOOP_BIT), .ADDR_W(ADDR_W)) bus ();

   conv_idx_addr #(.DATA_SIZE(DATA_SIZE), .LOOP_BIT(LOOP_BIT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .R(R), .C(C), .M(M), .N(N), .K(K), .S(S),
      .in_base(in_base), .w_base(w_base), .o_base(o_base),
      .bus(bus)
   );

   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;
   int      delivered = 0;
   int      rmode = 0;
   bundle_t exp_q[$];
   int      age_q[$];
   bundle_t obs_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the address formulas evaluated with plain 64-bit integers, then truncated.
   function automatic bundle_t model(input tuple_t t);
      bundle_t b;
      longint unsigned r, c, n, k, s, iw, ih, ia, wa, oa;
      r  = R; c = C; n = N; k = K; s = S;
      iw = (c - 1) * s + k;
      ih = (r - 1) * s + k;
      ia = in_base + (t.nn * ih + t.rr * s + t.ii) * iw + t.cc * s + t.jj;
      wa = w_base + ((t.mm * n + t.nn) * k + t.ii) * k + t.jj;
      oa = o_base + (t.mm * r + t.rr) * c + t.cc;
      b.in_addr = ia[19:0];
      b.w_addr  = wa[19:0];
      b.o_addr  = oa[19:0];
      b.first   = (t.nn == 0) && (t.ii == 0) && (t.jj == 0);
      b.last    = (int'(t.nn) == int'(N) - 1) && (int'(t.ii) == int'(K) - 1) &&
                  (int'(t.jj) == int'(K) - 1);
      b.lend    = b.last && (int'(t.mm) == int'(M) - 1) && (int'(t.cc) == int'(C) - 1) &&
                  (int'(t.rr) == int'(R) - 1);
      return b;
   endfunction

   // One clock: drive out_ready, check visible outputs against the queue head, then advance the model.
   task automatic tick(output bit acc);
      bit      ev, es, ordy;
      tuple_t  cur;
      bundle_t mb, got;
      case (rmode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = (cyc % 3 == 0);
         default: bus.out_ready = ($urandom_range(3) != 0);
      endcase
      #1;
      ordy = bus.out_ready;
      ev   = (exp_q.size() > 0) && (age_q[0] >= 3);
      es   = ev && !ordy;
      chk("out_valid", 64'(bus.out_valid), 64'(ev));
      chk("in_ready", 64'(bus.in_ready), 64'(!es));
      if (ev) begin
         got.in_addr = bus.in_addr;
         got.w_addr  = bus.w_addr;
         got.o_addr  = bus.o_addr;
         got.first   = bus.acc_first;
         got.last    = bus.acc_last;
         got.lend    = bus.layer_end;
         obs_b       = got;
         chk("in_addr", 64'(got.in_addr), 64'(exp_q[0].in_addr));
         chk("w_addr", 64'(got.w_addr), 64'(exp_q[0].w_addr));
         chk("o_addr", 64'(got.o_addr), 64'(exp_q[0].o_addr));
         chk("flags", 64'({got.first, got.last, got.lend}),
             64'({exp_q[0].first, exp_q[0].last, exp_q[0].lend}));
      end
      cur = {bus.rr, bus.cc, bus.mm, bus.nn, bus.ii, bus.jj};
      mb  = model(cur);
      acc = bus.in_valid && !es;
      @(posedge clk);
      if (!es) begin
         if (ev) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
            delivered++;
         end
         foreach (age_q[i]) age_q[i]++;
         if (acc) begin
            exp_q.push_back(mb);
            age_q.push_back(1);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic send(input tuple_t t);
      bit acc;
      int n = 0;
      {bus.rr, bus.cc, bus.mm, bus.nn, bus.ii, bus.jj} = t;
      bus.in_valid = 1'b1;
      do begin
         tick(acc);
         n++;
      end while (!acc && n < 40);
      if (!acc) chk("accept_timeout", 64'(0), 64'(1));
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      bus.in_valid = 1'b0;
      repeat (n) tick(acc);
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      bus.in_valid = 1'b0;
      while (exp_q.size() > 0 && n < 80) begin
         tick(acc);
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      age_q.delete();
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_addrs", 64'({bus.in_addr, bus.w_addr, bus.o_addr}), 64'(0));
      chk("rst_flags", 64'({bus.acc_first, bus.acc_last, bus.layer_end}), 64'(0));
   endtask

   // Single tuple against hand-computed constants.
   task automatic probe(input string tag, input tuple_t t, input logic [19:0] ei,
                        input logic [19:0] ew, input logic [19:0] eo, input logic [2:0] ef);
      drain();
      obs_b = '0;
      send(t);
      drain();
      chk({tag, "_in"}, 64'(obs_b.in_addr), 64'(ei));
      chk({tag, "_w"}, 64'(obs_b.w_addr), 64'(ew));
      chk({tag, "_o"}, 64'(obs_b.o_addr), 64'(eo));
      chk({tag, "_flags"}, 64'({obs_b.first, obs_b.last, obs_b.lend}), 64'(ef));
   endtask

   function automatic logic [7:0] rnd_idx(input logic [15:0] dim);
      if ($urandom_range(9) == 0) return 8'($urandom_range(255));
      return 8'($urandom_range(int'(dim) - 1));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tuple_t t;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      {bus.rr, bus.cc, bus.mm, bus.nn, bus.ii, bus.jj} = '0;
      R = 16'd2; C = 16'd2; M = 16'd1; N = 16'd1; K = 16'd3; S = 16'd1;
      in_base = 20'h100; w_base = 20'h200; o_base = 20'h300;
      do_reset();

      // Full 36-tuple layer in loop order, no backpressure
      rmode = 0;
      delivered = 0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  send({8'(r), 8'(c), 8'd0, 8'd0, 8'(i), 8'(j)});
      drain();
      chk("layer_count", 64'(delivered), 64'(36));
      probe("last_tuple", {8'd1, 8'd1, 8'd0, 8'd0, 8'd2, 8'd2}, 20'h10F, 20'h208, 20'h303, 3'b011);

      // Stride 2
      R = 16'd2; C = 16'd2; M = 16'd2; N = 16'd2; K = 16'd3; S = 16'd2;
      in_base = '0; w_base = '0; o_base = '0;
      probe("stride2", {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 20'd43, 20'd31, 20'd7, 3'b000);

      // Backpressure: out_ready 1,0,0 repeating
      rmode = 1;
      delivered = 0;
      for (int i = 0; i < 10; i++)
         send({8'(i % 2), 8'((i / 2) % 2), 8'(i % 2), 8'((i / 3) % 2), 8'(i % 3), 8'((i + 1) % 3)});
      drain();
      chk("bp_count", 64'(delivered), 64'(10));
      rmode = 0;

      // Flags with N=3, K=2
      R = 16'd2; C = 16'd2; M = 16'd1; N = 16'd3; K = 16'd2; S = 16'd1;
      probe("flag_first", {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 20'd0, 20'd0, 20'd0, 3'b100);
      probe("flag_last", {8'd1, 8'd1, 8'd0, 8'd2, 8'd1, 8'd1}, 20'd26, 20'd11, 20'd3, 3'b011);

      // Degenerate all-ones layer
      R = 16'd1; C = 16'd1; M = 16'd1; N = 16'd1; K = 16'd1; S = 16'd1;
      in_base = 20'h10; w_base = 20'h20; o_base = 20'h30;
      probe("ones", '0, 20'h10, 20'h20, 20'h30, 3'b111);

      // Address wrap
      R = 16'd2; C = 16'd2; M = 16'd1; N = 16'd1; K = 16'd3; S = 16'd1;
      in_base = 20'hFFFFE; w_base = '0; o_base = '0;
      probe("wrap", {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1}, 20'h00003, 20'd4, 20'd0, 3'b000);

      // Reset with tuples in flight
      in_base = 20'h100; w_base = 20'h200; o_base = 20'h300;
      for (int i = 0; i < 3; i++) send({8'd0, 8'd1, 8'd0, 8'd0, 8'(i), 8'd0});
      do_reset();
      idle(4);
      probe("post_rst", {8'd1, 8'd1, 8'd0, 8'd0, 8'd2, 8'd2}, 20'h10F, 20'h208, 20'h303, 3'b011);

      // Randomized configurations, tuples, gaps and backpressure
      rmode = 2;
      for (int cfg = 0; cfg < 4; cfg++) begin
         R = 16'($urandom_range(1, 40)); C = 16'($urandom_range(1, 40));
         M = 16'($urandom_range(1, 20)); N = 16'($urandom_range(1, 20));
         K = 16'($urandom_range(1, 5));  S = 16'($urandom_range(1, 4));
         in_base = 20'($urandom); w_base = 20'($urandom); o_base = 20'($urandom);
         for (int i = 0; i < 80; i++) begin
            t.rr = rnd_idx(R); t.cc = rnd_idx(C); t.mm = rnd_idx(M);
            t.nn = rnd_idx(N); t.ii = rnd_idx(K); t.jj = rnd_idx(K);
            if ($urandom_range(3) == 0) idle(1);
            send(t);
         end
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
